// File: rtl/config_regbank_pkg.sv
// rtl/config_regbank_pkg.sv - shared word map and defaults for the config register bank
// Purpose: word offsets of the fixed registers and the default ID constant.
// Ports: none (package).
package config_regbank_pkg;

  localparam int unsigned WORD_ID       = 0;
  localparam int unsigned WORD_STATUS   = 1;
  localparam int unsigned WORD_CNT_LO   = 2;
  localparam int unsigned WORD_CNT_HI   = 3;
  localparam int unsigned WORD_SCRATCH0 = 4;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hC0F1_0001;

endpackage

// File: rtl/config_rd_pipe.sv
// rtl/config_rd_pipe.sv - fixed-depth read-response delay line (valid, data, err)
// Purpose: delays a read response by DEPTH register stages.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_valid/i_data/i_err  response produced in the cycle rd is sampled
//   o_valid/o_data/o_err  response DEPTH cycles later; data/err are zero when o_valid is low
module config_rd_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_err,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_err
);

  logic             r_valid [DEPTH];
  logic [WIDTH-1:0] r_data  [DEPTH];
  logic             r_err   [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_data[i]  <= '0;
        r_err[i]   <= 1'b0;
      end
    end else begin
      // Data and err are masked at entry so every stage is zero unless valid.
      r_valid[0] <= i_valid;
      r_data[0]  <= i_valid ? i_data : '0;
      r_err[0]   <= i_valid & i_err;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
        r_err[i]   <= r_err[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];
  assign o_err   = r_err[DEPTH-1];

endmodule

// File: rtl/config_rd_regbank.sv
// rtl/config_rd_regbank.sv - config register bank: ID, sticky STATUS, 64-bit counter, scratch
// Purpose: word-addressed register bank with a fixed-latency, non-blocking read path.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rd, raddr                  read strobe and byte address
//   rdata, rvalid, decode_err  read response READ_LATENCY cycles after rd
//   wr, waddr, wdata, wstrb    write strobe, byte address, data, byte enables
//   event_in                   status event pulses, accumulated into STATUS
module config_rd_regbank
  import config_regbank_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    NUM_SCRATCH  = 4,
  parameter logic [31:0]           ID_VALUE     = ID_VALUE_DEFAULT,
  parameter int                    READ_LATENCY = 2,
  // Counter value loaded on reset; zero in normal use.
  parameter logic [63:0]           CNT_RESET    = '0,
  localparam int                   STRB_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0] event_in,
  output logic                  decode_err
);

  localparam int OFS_BITS  = $clog2(STRB_WIDTH);
  localparam int NUM_WORDS = WORD_SCRATCH0 + NUM_SCRATCH;

  logic [DATA_WIDTH-1:0] r_status;
  logic [63:0]           r_cnt;
  logic [31:0]           r_cnt_hi;
  logic [DATA_WIDTH-1:0] r_scratch [NUM_SCRATCH];

  // Address decode. Subtraction wraps for addresses below the base, so the
  // explicit compare is what rejects them.
  logic [ADDR_WIDTH-1:0] w_ridx, w_widx;
  logic                  w_rhit, w_whit;
  assign w_ridx = (raddr - BASE_ADDR) >> OFS_BITS;
  assign w_widx = (waddr - BASE_ADDR) >> OFS_BITS;
  assign w_rhit = (raddr >= BASE_ADDR) && (w_ridx < ADDR_WIDTH'(NUM_WORDS));
  assign w_whit = (waddr >= BASE_ADDR) && (w_widx < ADDR_WIDTH'(NUM_WORDS));

  logic w_rd_status, w_rd_cnt_lo;
  assign w_rd_status = rd && w_rhit && (w_ridx == ADDR_WIDTH'(WORD_STATUS));
  assign w_rd_cnt_lo = rd && w_rhit && (w_ridx == ADDR_WIDTH'(WORD_CNT_LO));

  // Zero-extend (or truncate) the fixed-width sources to DATA_WIDTH.
  logic [63:0]            w_cnt_lo64;
  logic [DATA_WIDTH+31:0] w_id_ext, w_hi_ext;
  logic [DATA_WIDTH+63:0] w_lo_ext;
  assign w_cnt_lo64 = (DATA_WIDTH >= 64) ? r_cnt : {32'b0, r_cnt[31:0]};
  assign w_id_ext   = {{DATA_WIDTH{1'b0}}, ID_VALUE};
  assign w_hi_ext   = {{DATA_WIDTH{1'b0}}, r_cnt_hi};
  assign w_lo_ext   = {{DATA_WIDTH{1'b0}}, w_cnt_lo64};

  logic [DATA_WIDTH-1:0] w_rd_data;
  always_comb begin
    w_rd_data = '0;
    if (w_rhit) begin
      if (w_ridx == ADDR_WIDTH'(WORD_ID))          w_rd_data = w_id_ext[DATA_WIDTH-1:0];
      else if (w_ridx == ADDR_WIDTH'(WORD_STATUS)) w_rd_data = r_status;
      else if (w_ridx == ADDR_WIDTH'(WORD_CNT_LO)) w_rd_data = w_lo_ext[DATA_WIDTH-1:0];
      else if (w_ridx == ADDR_WIDTH'(WORD_CNT_HI)) w_rd_data = w_hi_ext[DATA_WIDTH-1:0];
      else begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (w_ridx == ADDR_WIDTH'(WORD_SCRATCH0 + i)) w_rd_data = r_scratch[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= '0;
      r_cnt    <= CNT_RESET;
      r_cnt_hi <= '0;
    end else begin
      // A STATUS read hands off the current value and restarts accumulation
      // from this cycle's events, so nothing arriving with the read is lost.
      r_status <= w_rd_status ? event_in : (r_status | event_in);
      r_cnt    <= r_cnt + 64'd1;
      if (w_rd_cnt_lo) r_cnt_hi <= r_cnt[63:32];
    end
  end

  // Reads use the registered value, so a same-cycle write is seen by the next read only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= '0;
    end else if (wr && w_whit) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (w_widx == ADDR_WIDTH'(WORD_SCRATCH0 + i)) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wstrb[b]) r_scratch[i][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

  config_rd_pipe #(
    .DEPTH(READ_LATENCY),
    .WIDTH(DATA_WIDTH)
  ) u_rd_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(rd),
    .i_data (w_rd_data),
    .i_err  (~w_rhit),
    .o_valid(rvalid),
    .o_data (rdata),
    .o_err  (decode_err)
  );

endmodule

// File: doc/config_rd_regbank.md
CONFIG_RD_REGBANK -- requirements
Module: config_rd_regbank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of raddr/waddr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of rdata/wdata/event_in; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter BASE_ADDR, default 0, byte base address of the bank.
REQ-004 SHALL have parameter NUM_SCRATCH, default 4, number of scratch registers (1..16).
REQ-005 SHALL have parameter ID_VALUE, default 32'hC0F1_0001, constant returned at word 0.
REQ-006 SHALL have parameter READ_LATENCY, default 2, rd-to-rvalid latency (1 or 2 only).
REQ-007 SHALL have ports (name direction width meaning): clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-008 SHALL have ports rd in 1 read strobe; raddr in ADDR_WIDTH read byte address.
REQ-009 SHALL have ports rdata out DATA_WIDTH read data; rvalid out 1 read data valid (one pulse per rd).
REQ-010 SHALL have ports wr in 1 write strobe; waddr in ADDR_WIDTH; wdata in DATA_WIDTH; wstrb in STRB_WIDTH byte enables.
REQ-011 SHALL have ports event_in in DATA_WIDTH status event pulses; decode_err out 1 unmapped-read flag, aligned with rvalid.

Function
REQ-012 SHALL decode word index = (addr - BASE_ADDR) >> log2(STRB_WIDTH); low address bits ignored.
REQ-013 SHALL map: 0 ID (RO), 1 STATUS (RO, clear-on-read), 2 CNT_LO (RO), 3 CNT_HI shadow (RO), 4..3+NUM_SCRATCH scratch (RW).
REQ-014 SHALL assert rvalid exactly READ_LATENCY cycles after the cycle rd is sampled high, with rdata valid in that cycle.
REQ-015 SHALL accept rd on every cycle (no backpressure); N consecutive rd cycles yield N consecutive rvalid cycles, in order.
REQ-016 SHALL drive rdata to zero whenever rvalid is low.
REQ-017 SHALL return zero and assert decode_err with rvalid for an unmapped index or an address below BASE_ADDR.
REQ-018 SHALL set STATUS bits sticky: status_next = status | event_in each cycle.
REQ-019 SHALL, on a sampled STATUS read, return status as of that sample cycle and load status with event_in of that cycle (same-cycle events are never lost).
REQ-020 SHALL keep a 64-bit free-running counter, incrementing every cycle, wrapping 2^64-1 -> 0.
REQ-021 SHALL, on a sampled CNT_LO read, return counter[31:0] and capture counter[63:32] of the same cycle into the CNT_HI shadow.
REQ-022 SHALL, for DATA_WIDTH > 32, zero-extend ID/CNT words; for DATA_WIDTH = 64, CNT_LO returns the full 64-bit counter.
REQ-023 SHALL write scratch bytes where wstrb is set, on the cycle wr is high; writes to RO or unmapped words are ignored silently.
REQ-024 SHALL return the pre-write scratch value when rd and wr target the same scratch word in the same cycle.
REQ-025 SHALL treat rd and wr as independent; simultaneous operations to different words both complete.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear rvalid, rdata, decode_err, pipeline valids, STATUS, counter, CNT_HI shadow and all scratch to zero.
REQ-027 SHALL discard reads in flight when reset asserts mid-pipeline; no rvalid is produced for them after release.
REQ-028 SHALL sample rd/wr from the first rising clk edge after rst_n deasserts.

Structure
REQ-029 SHALL place word offsets (ID, STATUS, CNT_LO, CNT_HI, SCRATCH0) and the default ID_VALUE in shared package config_regbank_pkg.
REQ-030 SHALL implement the rd/raddr-to-rvalid delay line as sub-module config_rd_pipe (parameter depth, carries valid, data, err).
REQ-031 SHALL keep all read-path state in registers; no combinational path from rd/raddr to rdata/rvalid.

Verification
REQ-032 Reset, then rd with raddr=BASE+0 -> 2 cycles later rvalid=1, rdata=0xC0F10001, decode_err=0.
REQ-033 event_in=0x5 for one cycle, then rd STATUS -> rdata=0x5; second rd STATUS -> 0x0; event_in=0x2 in the same cycle as the read -> next read returns 0x2.
REQ-034 wr scratch0 wdata=0xAABBCCDD wstrb=4'b0101, then rd -> 0x00BB00DD; same-cycle rd+wr 0x11111111 strb=4'hF -> old value returned, next rd 0x11111111.
REQ-035 rd on 5 consecutive cycles (ID, STATUS, CNT_LO, CNT_HI, word 15) -> 5 consecutive rvalid, in order, decode_err only on the fifth.
REQ-036 rd CNT_LO at counter 0x1_FFFF_FFFF -> 0xFFFFFFFF; next rd CNT_HI -> 0x1 although counter has since wrapped its low word.
REQ-037 rd issued, rst_n pulsed low one cycle later -> rvalid stays 0; scratch reads 0 after release.
